// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pulls bytes from an upstream FIFO and serialises them
// as start + 8 data bits (LSB first) + optional parity + one or two stop bits.
module uart_tx_ctrl #(
    parameter logic [15:0] BAUD_DIV = 16'd347
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       p_empty_i,
    output logic       n_re_o,
    input  logic       p_parity_en_i,
    input  logic       p_parity_odd_i,
    input  logic       p_two_stop_i,
    output logic       tx_o,
    output logic       p_busy_o,
    output logic       p_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CNT = BAUD_DIV - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        two_stop_q, two_stop_d;
    logic        stop2_q, stop2_d;
    logic        tx_q, tx_d;
    logic        n_re_q, n_re_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end = (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;

        case (state_q)
            IDLE: begin
                if (!p_empty_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                // Frame configuration is frozen here so later input changes cannot corrupt it.
                shift_d    = data_i;
                par_en_d   = p_parity_en_i;
                par_bit_d  = (^data_i) ^ p_parity_odd_i;
                two_stop_d = p_two_stop_i;
                cnt_d      = 16'd0;
                idx_d      = 3'd0;
                stop2_d    = 1'b0;
                state_d    = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        stop2_d = 1'b0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    stop2_d = 1'b0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
        n_re_d = (state_d != FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == LAST_CNT) && (!two_stop_d || stop2_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            n_re_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            n_re_q     <= n_re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_o     = tx_q;
    assign n_re_o   = n_re_q;
    assign p_busy_o = busy_q;
    assign p_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with BAUD_DIV = 4 and a small FIFO model
// that answers each read strobe by presenting the next byte on data_i.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       p_empty_i;
    logic       n_re_o;
    logic       p_parity_en_i;
    logic       p_parity_odd_i;
    logic       p_two_stop_i;
    logic       tx_o;
    logic       p_busy_o;
    logic       p_done_o;

    int checks;
    int failures;

    logic [7:0] fifo[$];
    logic       tr_tx[$];
    logic       tr_done[$];
    logic       tr_nre[$];
    logic       tr_busy[$];

    uart_tx_ctrl #(
        .BAUD_DIV(16'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .p_empty_i     (p_empty_i),
        .n_re_o        (n_re_o),
        .p_parity_en_i (p_parity_en_i),
        .p_parity_odd_i(p_parity_odd_i),
        .p_two_stop_i  (p_two_stop_i),
        .tx_o          (tx_o),
        .p_busy_o      (p_busy_o),
        .p_done_o      (p_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge; a read strobe seen there pops the FIFO.
    task automatic tick();
        @(negedge clk);
        if (n_re_o === 1'b0 && fifo.size() != 0) begin
            data_i = fifo.pop_front();
        end
        p_empty_i = (fifo.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        p_empty_i = 1'b0;
    endtask

    task automatic record(input int n, input int chg_at);
        tr_tx.delete();
        tr_done.delete();
        tr_nre.delete();
        tr_busy.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            tr_tx.push_back(tx_o);
            tr_done.push_back(p_done_o);
            tr_nre.push_back(n_re_o);
            tr_busy.push_back(p_busy_o);
            if (i == chg_at) begin
                p_parity_en_i  = ~p_parity_en_i;
                p_parity_odd_i = ~p_parity_odd_i;
                p_two_stop_i   = ~p_two_stop_i;
            end
        end
    endtask

    task automatic test_reset();
        push(8'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx_o !== 1'b1 || n_re_o !== 1'b1 || p_busy_o !== 1'b0 || p_done_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold cyc=%0d tx=%b n_re=%b busy=%b done=%b required 1 1 0 0",
                         i, tx_o, n_re_o, p_busy_o, p_done_o);
            end
        end
    endtask

    task automatic test_frame_55();
        logic [9:0] exp_bits;
        int         n_lo;
        int         n_done;
        exp_bits = 10'b10_1010_1010;
        rst = 1'b1;
        record(50, -1);
        n_lo = 0;
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            if (tr_nre[i] === 1'b0) n_lo++;
            if (tr_done[i] === 1'b1) n_done++;
        end
        checks++;
        if (n_lo != 1 || tr_nre[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame55_read pulses=%0d first=%b required 1 0", n_lo, tr_nre[0]);
        end
        checks++;
        if (tr_tx[0] !== 1'b1 || tr_tx[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame55_pre tx=%b%b required 11", tr_tx[0], tr_tx[1]);
        end
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (tr_tx[2 + 4 * p + c] !== exp_bits[p]) begin
                    failures++;
                    $display("[TB] FAIL frame55_bit p=%0d c=%0d tx=%b required %b",
                             p, c, tr_tx[2 + 4 * p + c], exp_bits[p]);
                end
            end
        end
        checks++;
        if (n_done != 1 || tr_done[41] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame55_done pulses=%0d at41=%b required 1 1", n_done, tr_done[41]);
        end
        checks++;
        if (tr_busy[41] !== 1'b1 || tr_busy[42] !== 1'b0 || tr_tx[42] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame55_end busy41=%b busy42=%b tx42=%b required 1 0 1",
                     tr_busy[41], tr_busy[42], tr_tx[42]);
        end
    endtask

    task automatic test_parity_two_stop();
        logic [11:0] exp_bits;
        int          n_done;
        exp_bits = 12'b1101_0100_0110;
        p_parity_en_i  = 1'b1;
        p_parity_odd_i = 1'b0;
        p_two_stop_i   = 1'b1;
        push(8'hA3);
        record(52, 2);
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (tr_tx[2 + 4 * p + c] !== exp_bits[p]) begin
                    failures++;
                    $display("[TB] FAIL even2stop_bit p=%0d c=%0d tx=%b required %b",
                             p, c, tr_tx[2 + 4 * p + c], exp_bits[p]);
                end
            end
        end
        n_done = 0;
        for (int i = 0; i < 52; i++) begin
            if (tr_done[i] === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 1 || tr_done[49] !== 1'b1 || tr_busy[50] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL even2stop_len pulses=%0d done49=%b busy50=%b required 1 1 0",
                     n_done, tr_done[49], tr_busy[50]);
        end

        p_parity_en_i  = 1'b1;
        p_parity_odd_i = 1'b1;
        p_two_stop_i   = 1'b1;
        push(8'hA3);
        record(52, -1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (tr_tx[38 + c] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL odd_parity c=%0d tx=%b required 1", c, tr_tx[38 + c]);
            end
        end
        checks++;
        if (tr_done[49] !== 1'b1 || tr_done[48] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL odd_len done48=%b done49=%b required 0 1", tr_done[48], tr_done[49]);
        end
        p_parity_en_i  = 1'b0;
        p_parity_odd_i = 1'b0;
        p_two_stop_i   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got1;
        logic [7:0] got2;
        int         n_lo;
        int         n_done;
        push(8'h01);
        push(8'hFF);
        record(90, -1);
        n_lo = 0;
        n_done = 0;
        for (int i = 0; i < 90; i++) begin
            if (tr_nre[i] === 1'b0) n_lo++;
            if (tr_done[i] === 1'b1) n_done++;
        end
        checks++;
        if (n_lo != 2 || tr_nre[0] !== 1'b0 || tr_nre[43] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_reads pulses=%0d at0=%b at43=%b required 2 0 0",
                     n_lo, tr_nre[0], tr_nre[43]);
        end
        checks++;
        if (tr_tx[41] !== 1'b1 || tr_tx[42] !== 1'b1 || tr_tx[43] !== 1'b1 || tr_tx[44] !== 1'b1
            || tr_tx[45] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap tx41..45=%b%b%b%b%b required 11110",
                     tr_tx[41], tr_tx[42], tr_tx[43], tr_tx[44], tr_tx[45]);
        end
        for (int b = 0; b < 8; b++) begin
            got1[b] = tr_tx[2 + 4 * (1 + b) + 1];
            got2[b] = tr_tx[45 + 4 * (1 + b) + 1];
        end
        checks++;
        if (got1 !== 8'h01 || got2 !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL b2b_order got=%h,%h required 01,ff", got1, got2);
        end
        checks++;
        if (n_done != 2 || tr_done[41] !== 1'b1 || tr_done[84] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_done pulses=%0d at41=%b at84=%b required 2 1 1",
                     n_done, tr_done[41], tr_done[84]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        int         n_done;
        push(8'hC3);
        push(8'h5A);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (p_done_o === 1'b1) n_done++;
            if (i == 19) begin
                checks++;
                if (p_busy_o !== 1'b1 || tx_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL midframe_bit3 busy=%b tx=%b required 1 0", p_busy_o, tx_o);
                end
                rst = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (p_done_o === 1'b1) n_done++;
            checks++;
            if (tx_o !== 1'b1 || p_busy_o !== 1'b0 || n_re_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL midframe_abort cyc=%0d tx=%b busy=%b n_re=%b required 1 0 1",
                         i, tx_o, p_busy_o, n_re_o);
            end
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("[TB] FAIL midframe_nodone pulses=%0d required 0", n_done);
        end
        rst = 1'b1;
        record(45, -1);
        for (int b = 0; b < 8; b++) begin
            got[b] = tr_tx[2 + 4 * (1 + b) + 1];
        end
        checks++;
        if (tr_nre[0] !== 1'b0 || tr_tx[2] !== 1'b0 || got !== 8'h5A || tr_done[41] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midframe_restart n_re0=%b start=%b byte=%h done41=%b required 0 0 5a 1",
                     tr_nre[0], tr_tx[2], got, tr_done[41]);
        end
    endtask

    task automatic test_idle_empty();
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (n_re_o !== 1'b1 || tx_o !== 1'b1 || p_busy_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_empty cyc=%0d n_re=%b tx=%b busy=%b required 1 1 0",
                         i, n_re_o, tx_o, p_busy_o);
            end
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        data_i         = 8'h00;
        p_empty_i      = 1'b1;
        p_parity_en_i  = 1'b0;
        p_parity_odd_i = 1'b0;
        p_two_stop_i   = 1'b0;
        tick();
        tick();
        test_reset();
        test_frame_55();
        test_parity_two_stop();
        test_back_to_back();
        test_reset_midframe();
        test_idle_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
